// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes 32-bit words into instruction memory
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      word_buf_q, word_buf_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [CNT_W-1:0] count_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        in_ready   = 1'b0;
        count_full = {in_data, count_q[7:0]};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            S_LEN0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d[7:0] = in_data;
                    state_d      = S_LEN1;
                end
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = count_full;
                    if (count_full == '0)
                        state_d = S_DONE;
                    else if (count_full > CNT_W'(DEPTH))
                        state_d = S_ERR;
                    else
                        state_d = S_WORD;
                end
            end
            S_WORD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = in_data;
                        2'd1: word_buf_d[15:8]  = in_data;
                        2'd2: word_buf_d[23:16] = in_data;
                        default: begin
                            // Last byte goes straight into the write register so the
                            // word is complete on the strobe cycle.
                            wr_data_d = {in_data, word_buf_q};
                            wr_addr_d = {{(30-CNT_W){1'b0}}, word_idx_q, 2'b00};
                            state_d   = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (word_idx_q + CNT_W'(1) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + CNT_W'(1);
                    state_d    = S_WORD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en    = (state_q == S_WRITE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It issues one word write per instruction into the instruction memory's write port, at word-aligned byte addresses starting at 0. While loading, it holds the processor core in reset so no fetch observes a partially written image.

Parameters:
DEPTH, 32, number of 32-bit words in the instruction memory; word counts above this are rejected
CNT_W, 16, width of the word-count header field (fixed two header bytes; CNT_W must be 16)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load session; sampled in IDLE, DONE, ERR
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
wr_en  output  1  one-cycle write strobe to instruction memory
wr_addr  output  32  byte address of write, always word aligned (bits[1:0]=0)
wr_data  output  32  instruction word to write
cpu_hold  output  1  holds core in reset while a session is active
done  output  1  level: last session completed successfully
err  output  1  level: last session rejected (count > DEPTH)

Behaviour:
- Reset (sync, high): state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0; byte/word counters cleared. Reset mid-session aborts immediately; no further wr_en; partially written memory contents are left as is.
- States: IDLE, LEN0, LEN1, WORD, WRITE, DONE, ERR.
- IDLE/DONE/ERR: in_ready=0. start=1 -> LEN0; clear done, err, word index, byte index; cpu_hold=1 from the next cycle.
- LEN0: in_ready=1; on transfer, count[7:0]=in_data -> LEN1.
- LEN1: in_ready=1; on transfer, count[15:8]=in_data. Next state uses the full 16-bit count:
  - count==0 -> DONE
  - count>DEPTH -> ERR
  - otherwise -> WORD
- WORD: in_ready=1; byte k (0..3) goes to wr_data[8k+7:8k]; byte index increments per transfer only. On the 4th transfer -> WRITE; byte index wraps to 0.
- WRITE: in_ready=0 (one bubble cycle per word); wr_en=1 for exactly this cycle; wr_addr={word_idx,2'b00}. Stream bytes are not consumed in this cycle.
  - word_idx+1==count -> DONE
  - otherwise word_idx++ -> WORD
- wr_addr/wr_data are registered and stable during the wr_en cycle. Their values outside wr_en are don't-care but hold the last value.
- DONE: done=1, cpu_hold=0. ERR: err=1, cpu_hold=1 (core stays held until reset or a successful reload).
- cpu_hold=1 in LEN0, LEN1, WORD, WRITE, ERR; 0 in IDLE and DONE.
- start is ignored in LEN0/LEN1/WORD/WRITE.
- in_valid=0 stalls any state without timeout; partial byte assembly is preserved across stalls.
- Max session = 2 + 4*DEPTH accepted bytes. Throughput: 5 cycles per word at full in_valid.
- Bytes following the final word are not accepted (in_ready=0 in DONE).

Test Plan:
- Reset, start, stream 02 00 93 01 10 00 33 89 08 01 with in_valid constant 1 -> wr_en at addr 0x0 data 0x00100193, then addr 0x4 data 0x01088933; exactly 2 strobes; done=1, cpu_hold=0 at end; cpu_hold=1 throughout load.
- Same stream with in_valid toggling 1/0 every cycle -> identical writes and data; no byte lost or duplicated; in_ready=0 on both WRITE cycles.
- Header 00 00 -> no wr_en; done=1 the cycle after the second byte; err=0.
- Header 21 00 (33 > DEPTH=32) -> ERR; err=1, cpu_hold=1, in_ready=0, no wr_en; later start plus a valid 1-word image -> err clears, done=1.
- Full image of 32 words (header 20 00, word i = i) -> last write at addr 0x7C data 0x0000001F; done=1.
- Assert reset after 2 of 4 bytes of word 1 -> all outputs 0 next cycle; a new start plus 1-word image writes addr 0x0 with the new word, with no stale bytes mixed in.
